game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_if.sv | 30 +++
 rtl/game_sequencer.sv | 169 ++++++++++++++++
 tb/tb_game_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - handshake/status bundle between game logic and game_sequencer
// pause exists only when SEQ_PAUSE_EN is defined.
interface game_sequencer_if;
  logic       frame_start;
  logic       start;
  logic       shark_hit;
  logic       bottle_hit;
`ifdef SEQ_PAUSE_EN
  logic       pause;
`endif
  logic       shark_ack;
  logic       bottle_ack;
  logic       move_tick;
  logic       reload;
  logic [2:0] state;
  logic [2:0] lives;
  logic [3:0] score;

`ifdef SEQ_PAUSE_EN
  modport master (output frame_start, start, shark_hit, bottle_hit, pause,
                  input  shark_ack, bottle_ack, move_tick, reload, state, lives, score);
  modport slave  (input  frame_start, start, shark_hit, bottle_hit, pause,
                  output shark_ack, bottle_ack, move_tick, reload, state, lives, score);
`else
  modport master (output frame_start, start, shark_hit, bottle_hit,
                  input  shark_ack, bottle_ack, move_tick, reload, state, lives, score);
  modport slave  (input  frame_start, start, shark_hit, bottle_hit,
                  output shark_ack, bottle_ack, move_tick, reload, state, lives, score);
`endif
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game flow FSM: lives, score, move ticks, respawn and request acks
// Optional pause feature enabled by defining SEQ_PAUSE_EN.
module game_sequencer #(
  parameter int LIVES          = 3,
  parameter int WIN_BOTTLES    = 8,
  parameter int RESPAWN_FRAMES = 60,
  parameter int TICK_DIV       = 2
) (
  input  logic            clk,
  input  logic            rst,
  game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_RESPAWN   = 3'd2,
    S_GAME_OVER = 3'd3,
    S_WIN       = 3'd4,
    S_PAUSED    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] score_q, score_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] respawn_cnt_q, respawn_cnt_d;
  logic       shark_ack_q, shark_ack_d;
  logic       bottle_ack_q, bottle_ack_d;
  logic       move_tick_q, move_tick_d;
  logic       reload_q, reload_d;
  logic       hold_req;
  logic       pause_req;
  logic       take_shark;
  logic       take_bottle;
  logic [3:0] score_inc;

`ifdef SEQ_PAUSE_EN
  assign pause_req = bus.pause;
`else
  assign pause_req = 1'b0;
`endif

  // A request is taken only if its ack was low last cycle, so acks never repeat back to back.
  assign take_shark  = bus.shark_hit  && !shark_ack_q;
  assign take_bottle = bus.bottle_hit && !bottle_ack_q;
  assign score_inc   = (score_q == 4'd15) ? score_q : score_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lives_q       <= 3'd0;
      score_q       <= 4'd0;
      frame_cnt_q   <= 4'd0;
      respawn_cnt_q <= 8'd0;
      shark_ack_q   <= 1'b0;
      bottle_ack_q  <= 1'b0;
      move_tick_q   <= 1'b0;
      reload_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      frame_cnt_q   <= frame_cnt_d;
      respawn_cnt_q <= respawn_cnt_d;
      shark_ack_q   <= shark_ack_d;
      bottle_ack_q  <= bottle_ack_d;
      move_tick_q   <= move_tick_d;
      reload_q      <= reload_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    score_d       = score_q;
    frame_cnt_d   = frame_cnt_q;
    respawn_cnt_d = respawn_cnt_q;
    move_tick_d   = 1'b0;
    reload_d      = 1'b0;
    hold_req      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_PLAY;
          reload_d    = 1'b1;
          lives_d     = 3'(LIVES);
          score_d     = 4'd0;
          frame_cnt_d = 4'd0;
        end
      end

      S_PLAY: begin
        if (pause_req) begin
          state_d  = S_PAUSED;
          hold_req = 1'b1;
        end else begin
          if (bus.frame_start) begin
            if (frame_cnt_q == 4'(TICK_DIV - 1)) begin
              move_tick_d = 1'b1;
              frame_cnt_d = 4'd0;
            end else begin
              frame_cnt_d = frame_cnt_q + 4'd1;
            end
          end
          // Shark wins over a simultaneous bottle; the bottle is still acked but not scored.
          if (take_shark) begin
            if (lives_q > 3'd1) begin
              lives_d       = lives_q - 3'd1;
              reload_d      = 1'b1;
              respawn_cnt_d = 8'(RESPAWN_FRAMES);
              state_d       = S_RESPAWN;
            end else begin
              lives_d = 3'd0;
              state_d = S_GAME_OVER;
            end
          end else if (take_bottle) begin
            score_d = score_inc;
            if (score_inc == 4'(WIN_BOTTLES)) begin
              state_d = S_WIN;
            end
          end
        end
      end

      S_RESPAWN: begin
        if (bus.frame_start) begin
          if (respawn_cnt_q <= 8'd1) begin
            respawn_cnt_d = 8'd0;
            frame_cnt_d   = 4'd0;
            state_d       = S_PLAY;
          end else begin
            respawn_cnt_d = respawn_cnt_q - 8'd1;
          end
        end
      end

      S_GAME_OVER, S_WIN: begin
        if (bus.start) begin
          state_d = S_IDLE;
        end
      end

`ifdef SEQ_PAUSE_EN
      S_PAUSED: begin
        hold_req = 1'b1;
        if (pause_req) begin
          state_d = S_PLAY;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    shark_ack_d  = take_shark  && !hold_req;
    bottle_ack_d = take_bottle && !hold_req;
  end

  assign bus.state      = state_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.shark_ack  = shark_ack_q;
  assign bus.bottle_ack = bottle_ack_q;
  assign bus.move_tick  = move_tick_q;
  assign bus.reload     = reload_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized scoreboard bench for game_sequencer
// Driver updates a rule-level game model and queues expected pulse records; a monitor checks them.
module tb_game_sequencer;
  localparam int LIVES          = 3;
  localparam int WIN_BOTTLES    = 8;
  localparam int RESPAWN_FRAMES = 60;
  localparam int TICK_DIV       = 2;

  typedef struct packed {
    logic       sa;
    logic       ba;
    logic       mt;
    logic       rl;
    logic [2:0] st;
    logic [2:0] lv;
    logic [3:0] sc;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  game_sequencer_if bus();

  game_sequencer #(
    .LIVES(LIVES), .WIN_BOTTLES(WIN_BOTTLES),
    .RESPAWN_FRAMES(RESPAWN_FRAMES), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   ticks_seen = 0;
  rec_t exp_q[$];

  // Game model in plain integers: 0 idle, 1 play, 2 respawn, 3 game over, 4 win, 5 paused.
  int m_st, m_lives, m_score, m_frames, m_respawn;

  function automatic rec_t snap(input bit sa, input bit ba, input bit mt, input bit rl);
    rec_t r;
    r.sa = sa; r.ba = ba; r.mt = mt; r.rl = rl;
    r.st = 3'(m_st); r.lv = 3'(m_lives); r.sc = 4'(m_score);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && (bus.shark_ack || bus.bottle_ack || bus.move_tick || bus.reload)) begin
      rec_t got, want;
      got = {bus.shark_ack, bus.bottle_ack, bus.move_tick, bus.reload, bus.state, bus.lives, bus.score};
      if (bus.move_tick) ticks_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got=%h (sa,ba,mt,rl,st,lv,sc) required=no pulse", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL pulse_record got=%h required=%h t=%0t", got, want, $time);
        end
      end
    end
  end

  task automatic model_reset();
    m_st = 0; m_lives = 0; m_score = 0; m_frames = 0; m_respawn = 0;
  endtask

  task automatic do_frame();
    if (m_st == 1) begin
      m_frames++;
      if (m_frames == TICK_DIV) begin
        m_frames = 0;
        exp_q.push_back(snap(0, 0, 1, 0));
      end
    end else if (m_st == 2) begin
      m_respawn--;
      if (m_respawn == 0) begin m_st = 1; m_frames = 0; end
    end
    @(negedge clk); bus.frame_start = 1'b1;
    @(negedge clk); bus.frame_start = 1'b0;
  endtask

  task automatic do_start();
    if (m_st == 0) begin
      m_st = 1; m_lives = LIVES; m_score = 0; m_frames = 0;
      exp_q.push_back(snap(0, 0, 0, 1));
    end else if (m_st == 3 || m_st == 4) begin
      m_st = 0;
    end
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic model_req(input bit s, input bit b);
    bit rl = 0;
    if (m_st == 1) begin
      if (s) begin
        if (m_lives > 1) begin
          m_lives--; rl = 1; m_respawn = RESPAWN_FRAMES; m_st = 2;
        end else begin
          m_lives = 0; m_st = 3;
        end
      end else if (b) begin
        if (m_score < 15) m_score++;
        if (m_score == WIN_BOTTLES) m_st = 4;
      end
    end
    exp_q.push_back(snap(s, b, 0, rl));
  endtask

  task automatic do_req(input bit s, input bit b);
    bit got = 0;
    model_req(s, b);
    @(negedge clk); bus.shark_hit = s; bus.bottle_hit = b;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((s && bus.shark_ack) || (b && bus.bottle_ack)) begin got = 1; break; end
    end
    bus.shark_hit = 1'b0; bus.bottle_hit = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL req_ack_timeout shark=%0d bottle=%0d got=no ack required=ack within 8 cycles", s, b);
    end
  endtask

`ifdef SEQ_PAUSE_EN
  task automatic do_pause();
    if (m_st == 1) m_st = 5;
    else if (m_st == 5) m_st = 1;
    @(negedge clk); bus.pause = 1'b1;
    @(negedge clk); bus.pause = 1'b0;
  endtask
`endif

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  initial begin
    bus.frame_start = 0; bus.start = 0; bus.shark_hit = 0; bus.bottle_hit = 0;
`ifdef SEQ_PAUSE_EN
    bus.pause = 0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset_state", bus.state, 0);
    check_val("reset_lives", bus.lives, 0);
    check_val("reset_score", bus.score, 0);
    check_val("reset_pulses", {bus.shark_ack, bus.bottle_ack, bus.move_tick, bus.reload}, 0);
    rst = 1'b0;

    do_start();
    ticks_seen = 0;
    repeat (6) do_frame();
    @(negedge clk);
    check_val("six_frames_ticks", ticks_seen, 3);

    do_req(0, 1); do_req(0, 1); do_req(0, 1);
    do_req(1, 1);
    check_val("both_hit_lives", m_lives, 2);
    repeat (RESPAWN_FRAMES) do_frame();
    do_req(1, 0);
    repeat (RESPAWN_FRAMES) do_frame();
    do_req(1, 0);
    @(negedge clk);
    check_val("game_over_state", bus.state, 3);
    do_start();
    @(negedge clk);
    check_val("over_to_idle", bus.state, 0);

    do_start();
    repeat (WIN_BOTTLES) do_req(0, 1);
    @(negedge clk);
    check_val("win_state", bus.state, 4);
    check_val("win_score", bus.score, WIN_BOTTLES);
    do_req(1, 0);

`ifdef SEQ_PAUSE_EN
    do_start(); do_start();
    do_frame();
    do_pause();
    ticks_seen = 0;
    repeat (10) do_frame();
    @(negedge clk); bus.shark_hit = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_val("paused_no_ack", bus.shark_ack, 0);
    end
    check_val("paused_no_tick", ticks_seen, 0);
    m_st = 1;
    model_req(1, 0);
    m_st = 5;
    do_pause();
    for (int i = 0; i < 8 && bus.shark_hit; i++) begin
      @(negedge clk);
      if (bus.shark_ack) bus.shark_hit = 1'b0;
    end
    check_val("unpause_ack", bus.shark_hit, 0);
    bus.shark_hit = 1'b0;
`endif

    for (int n = 0; n < 300; n++) begin
      int pick;
      pick = $urandom_range(0, 99);
      if (pick < 30) do_frame();
      else if (pick < 38) repeat ($urandom_range(1, 70)) do_frame();
      else if (pick < 48) do_start();
`ifdef SEQ_PAUSE_EN
      else if (pick < 54) do_pause();
      else if (m_st == 5) do_frame();
`endif
      else if (pick < 75) do_req(0, 1);
      else if (pick < 90) do_req(1, 0);
      else do_req(1, 1);
    end

    if (m_st == 0) do_start();
    @(negedge clk);
    bus.shark_hit = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("reset_abort_no_ack", bus.shark_ack, 0);
    end
    check_val("reset_abort_state", bus.state, 0);
    bus.shark_hit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    repeat (4) @(negedge clk);
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
